// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache and the D-cache.
// A single request is latched at a time, issued to memory and its response
// is steered back to the owning cache. Simultaneous requests alternate
// round-robin. Saturating grant counters support stall analysis.
//
// Request/response contract: a cache raises its request level (i_read,
// d_read, d_write) and holds it, with address and data stable, until it
// sees its one-cycle x_resp pulse. It must drop the level in the cycle
// after x_resp (RELEASE). The arbiter samples requests only in IDLE, so a
// level still high in RELEASE is never re-granted. Memory sees a command
// level (mem_read / mem_write) held until it pulses mem_resp.
module mem_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // data-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // physical memory port
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    // status
    output logic              busy,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Which side won the most recent grant; used to break ties.
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    // FSM state is kept in a plainly named register so checkers can bind to it.
    state_t state;
    state_t state_next;

    logic              last_grant;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LINE_W-1:0] cmd_wdata;
    logic              cmd_write;
    logic [CNT_W-1:0]  i_cnt;
    logic [CNT_W-1:0]  d_cnt;

    logic i_pend;
    logic d_pend;
    logic grant_i;
    logic grant_d;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // Arbitration: only in IDLE; a tie goes to the side that did not win last.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_pend && d_pend) begin
                if (last_grant == SIDE_D) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else begin
                grant_i = i_pend;
                grant_d = d_pend;
            end
        end
    end

    // State register; reset drops any in-flight transaction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant -> serve until mem_resp -> one release cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    state_next = SERVE_I;
                end else if (grant_d) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: commands only while serving; resp is combinational on mem_resp.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            SERVE_I: begin
                mem_read  = ~cmd_write;
                mem_write = cmd_write;
                i_resp    = mem_resp;
            end
            SERVE_D: begin
                mem_read  = ~cmd_write;
                mem_write = cmd_write;
                d_resp    = mem_resp;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    // Command registers: captured on the grant edge, held until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_write <= 1'b0;
        end else if (grant_i) begin
            cmd_addr  <= i_addr;
            cmd_write <= 1'b0;
        end else if (grant_d) begin
            cmd_addr  <= d_addr;
            cmd_wdata <= d_wdata;
            // write-back wins when the D-cache raises both
            cmd_write <= d_write;
        end
    end

    // Round-robin history; reset to D so the first tie is granted to I.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SIDE_D;
        end else if (grant_i) begin
            last_grant <= SIDE_I;
        end else if (grant_d) begin
            last_grant <= SIDE_D;
        end
    end

    // Grant counters: bump on the grant edge only, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            d_cnt <= '0;
        end else begin
            if (grant_i && (i_cnt != {CNT_W{1'b1}})) begin
                i_cnt <= i_cnt + CNT_W'(1);
            end
            if (grant_d && (d_cnt != {CNT_W{1'b1}})) begin
                d_cnt <= d_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_grants  = i_cnt;
    assign d_grants  = d_cnt;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single physical-memory port between the pipeline's instruction cache (fetch side, I) and data cache (memory stage, D). It latches one request at a time, presents it to memory, and routes the response back to the owning cache. Requests collide when a fetch and a load/store miss are outstanding together; ties alternate round-robin so neither stage starves. Saturating grant counters support stall analysis.

## Interface
- `LINE_W`, 128: cache line width in bits.
- `ADDR_W`, 16: byte address width.
- `CNT_W`, 16: width of each grant counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  I-cache read request, held until `i_resp`.
- `i_addr`  in  ADDR_W  I-cache line address.
- `i_rdata`  out  LINE_W  read data to I-cache.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_read`  in  1  D-cache read request, held until `d_resp`.
- `d_write`  in  1  D-cache write-back request, held until `d_resp`.
- `d_addr`  in  ADDR_W  D-cache line address.
- `d_wdata`  in  LINE_W  D-cache write-back data.
- `d_rdata`  out  LINE_W  read data to D-cache.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `mem_read`  out  1  memory read command.
- `mem_write`  out  1  memory write command.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  LINE_W  memory write data.
- `mem_rdata`  in  LINE_W  memory read data.
- `mem_resp`  in  1  memory completion pulse.
- `busy`  out  1  high in any state other than IDLE.
- `i_grants`, `d_grants`  out  CNT_W  saturating counts of grants issued.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: `d_pend = d_read|d_write`, `i_pend = i_read`.
  - Only one pending: grant it.
  - Both pending: grant the side not equal to `last_grant`.
  - On grant, latch into command registers:
    - `addr` from the granted requester.
    - `op`: write if `d_write` (wins if `d_read` also high), else read.
    - `wdata` from `d_wdata` (latched for D grants only).
  - On grant, set `last_grant`, increment that side's counter (hold at all-ones), move to SERVE_x.
- SERVE_x:
  - `mem_read`/`mem_write` per latched op.
  - `mem_addr`/`mem_wdata` from latched registers.
  - Requester inputs are ignored while serving. Dropping a request mid-service does not abort it.
  - On `mem_resp`: pulse x_resp the same cycle (combinational from `mem_resp` and state), then go to RELEASE.
- RELEASE: one cycle, no memory command. Lets the served cache drop its held request so a stale level is never re-granted. Then go to IDLE.
- `i_rdata` and `d_rdata` are both wired to `mem_rdata`; only the resp strobe qualifies them.
- `mem_read`, `mem_write`, `i_resp`, `d_resp` are 0 in IDLE and RELEASE.
- `mem_addr`/`mem_wdata` hold the last latched values outside SERVE.

## Timing
- Reset (async, immediate):
  - State IDLE.
  - All commands and resp outputs 0.
  - Latched addr/wdata 0.
  - Counters 0.
  - `last_grant` = D, so the first tie goes to I.
- Request first high in cycle 0 with arbiter in IDLE: mem command asserted in cycle 1.
- `mem_resp` in cycle n: x_resp in cycle n, RELEASE in n+1, IDLE in n+2. A new grant can be sampled at the end of n+2, so the next mem command appears no earlier than n+3.
- Minimum spacing between two memory commands: two idle cycles (RELEASE + IDLE).
- `mem_resp` arriving in IDLE or RELEASE is ignored: no resp pulse, no state change.
- `mem_resp` asserted in the same cycle the command first appears is legal; the transaction completes in one SERVE cycle.
- Reset mid-SERVE: the transaction is dropped immediately, with no resp to the requester. The memory model must also be reset.
- Counters increment on the grant edge only, never during SERVE or RELEASE.

## Test plan
1. I-only read, `i_addr`=16'h1230, memory responds 3 cycles after command with data L:
   - `mem_read` high cycles 1-4 with `mem_addr`=16'h1230.
   - `i_resp`=1 and `i_rdata`=L in cycle 4.
   - `busy` 0 by cycle 6; `i_grants`=1.
2. Simultaneous I read 16'h0040 and D write 16'h8000 from reset:
   - I is served first, then D (mem_write, wdata passed through).
   - Next tie goes to I again only after D has been served.
3. D asserts `d_read` and `d_write` together:
   - `mem_write`=1, `mem_read`=0.
   - `d_resp` on `mem_resp`.
4. D drops `d_read` one cycle after grant:
   - Command is held until `mem_resp`, `d_resp` still pulses.
   - No re-grant in RELEASE.
5. `rst_n` low mid-SERVE_D:
   - All outputs 0 within the same cycle; IDLE after release.
   - Counters 0 and first tie goes to I.
6. CNT_W=2 with five I grants: `i_grants` reads 1,2,3,3,3.
